// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction and a data request port onto one shared memory port and
// routes responses back in issue order. Optional `MERLIN_ARB_ROUND_ROBIN_EN selects round-robin.
module mem_port_arbiter #(
  parameter int C_FIFO_DEPTH_X = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_en_i,
  output logic        ireqready_o,
  input  logic        ireqvalid_i,
  input  logic [1:0]  ireqhpl_i,
  input  logic [31:0] ireqaddr_i,
  input  logic        irspready_i,
  output logic        irspvalid_o,
  output logic        irsprerr_o,
  output logic [31:0] irspdata_o,
  output logic        dreqready_o,
  input  logic        dreqvalid_i,
  input  logic [1:0]  dreqhpl_i,
  input  logic [31:0] dreqaddr_i,
  input  logic        drspready_i,
  output logic        drspvalid_o,
  output logic        drsprerr_o,
  output logic        drspwerr_o,
  output logic [31:0] drspdata_o,
  input  logic        mreqready_i,
  output logic        mreqvalid_o,
  output logic [1:0]  mreqhpl_o,
  output logic [31:0] mreqaddr_o,
  output logic        mrspready_o,
  input  logic        mrspvalid_i,
  input  logic        mrsprerr_i,
  input  logic        mrspwerr_i,
  input  logic [31:0] mrspdata_i
);

  localparam int FIFO_DEPTH = 1 << C_FIFO_DEPTH_X;
  localparam logic [C_FIFO_DEPTH_X:0] FIFO_FULL_CNT = {1'b1, {C_FIFO_DEPTH_X{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} arb_state_t;

  arb_state_t                state_reg;
  logic [C_FIFO_DEPTH_X-1:0] wr_ptr_reg;
  logic [C_FIFO_DEPTH_X-1:0] rd_ptr_reg;
  logic [C_FIFO_DEPTH_X:0]   count_reg;
  logic                      fifo_mem [FIFO_DEPTH];

  logic favour_d;
  logic gnt_d;
  logic gnt_valid;
  logic fifo_full;
  logic fifo_empty;
  logic head_d;
  logic push;
  logic pop;

  assign fifo_full  = (count_reg == FIFO_FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign head_d     = fifo_mem[rd_ptr_reg];

  // Lock states pin the grant so address/privilege cannot change under a stalled request.
  always_comb begin
    gnt_d = 1'b0;
    case (state_reg)
      LOCK_I:  gnt_d = 1'b0;
      LOCK_D:  gnt_d = 1'b1;
      default: gnt_d = dreqvalid_i & (~ireqvalid_i | favour_d);
    endcase
  end

  assign gnt_valid   = gnt_d ? dreqvalid_i : ireqvalid_i;
  assign mreqvalid_o = ~reset_i & gnt_valid & ~fifo_full;
  assign mreqhpl_o   = gnt_d ? dreqhpl_i : ireqhpl_i;
  assign mreqaddr_o  = gnt_d ? dreqaddr_i : ireqaddr_i;
  assign ireqready_o = ~reset_i & mreqready_i & ~fifo_full & ~gnt_d;
  assign dreqready_o = ~reset_i & mreqready_i & ~fifo_full & gnt_d;

  assign mrspready_o = ~reset_i & ~fifo_empty & (head_d ? drspready_i : irspready_i);
  assign irspvalid_o = ~reset_i & ~fifo_empty & ~head_d & mrspvalid_i;
  assign drspvalid_o = ~reset_i & ~fifo_empty & head_d & mrspvalid_i;
  assign irsprerr_o  = mrsprerr_i;
  assign irspdata_o  = mrspdata_i;
  assign drsprerr_o  = mrsprerr_i;
  assign drspwerr_o  = mrspwerr_i;
  assign drspdata_o  = mrspdata_i;

  assign push = mreqvalid_o & mreqready_i & clk_en_i;
  assign pop  = mrspvalid_i & mrspready_o & clk_en_i;

`ifdef MERLIN_ARB_ROUND_ROBIN_EN
  logic rr_favour_d_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_favour_d_reg <= 1'b1;
    end else if (push) begin
      rr_favour_d_reg <= ~gnt_d;
    end
  end

  assign favour_d = rr_favour_d_reg;
`else
  assign favour_d = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
    end else if (clk_en_i) begin
      case (state_reg)
        IDLE: begin
          if (mreqvalid_o && !mreqready_i) state_reg <= gnt_d ? LOCK_D : LOCK_I;
        end
        default: begin
          if (push) state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= gnt_d;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected request and response beats are queued
// at stimulus time and compared by monitors when the DUT completes a handshake.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        clk_en_i;
  logic        ireqready_o, ireqvalid_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspready_i, irspvalid_o, irsprerr_o;
  logic [31:0] irspdata_o;
  logic        dreqready_o, dreqvalid_i;
  logic [1:0]  dreqhpl_i;
  logic [31:0] dreqaddr_i;
  logic        drspready_i, drspvalid_o, drsprerr_o, drspwerr_o;
  logic [31:0] drspdata_o;
  logic        mreqready_i, mreqvalid_o;
  logic [1:0]  mreqhpl_o;
  logic [31:0] mreqaddr_o;
  logic        mrspready_o, mrspvalid_i, mrsprerr_i, mrspwerr_i;
  logic [31:0] mrspdata_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [33:0] exp_mreq[$];
  logic [32:0] exp_irsp[$];
  logic [33:0] exp_drsp[$];

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.C_FIFO_DEPTH_X(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
    .ireqaddr_i(ireqaddr_i), .irspready_i(irspready_i), .irspvalid_o(irspvalid_o),
    .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqhpl_i(dreqhpl_i),
    .dreqaddr_i(dreqaddr_i), .drspready_i(drspready_i), .drspvalid_o(drspvalid_o),
    .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o), .drspdata_o(drspdata_o),
    .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqhpl_o(mreqhpl_o),
    .mreqaddr_o(mreqaddr_o), .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i),
    .mrsprerr_i(mrsprerr_i), .mrspwerr_i(mrspwerr_i), .mrspdata_i(mrspdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clk_en_i = 1'b1;
    ireqvalid_i = 1'b0; ireqhpl_i = 2'd0; ireqaddr_i = '0;
    dreqvalid_i = 1'b0; dreqhpl_i = 2'd0; dreqaddr_i = '0;
    irspready_i = 1'b0; drspready_i = 1'b0; mreqready_i = 1'b0;
    mrspvalid_i = 1'b0; mrsprerr_i = 1'b0; mrspwerr_i = 1'b0; mrspdata_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    idle_inputs();
    reset_i = 1'b0;
    step();
  endtask

  // Monitors sample half a cycle after the inputs settle, away from the rising edge.
  always @(negedge clk_i) begin
    if (!reset_i && clk_en_i && mreqvalid_o && mreqready_i) begin
      if (exp_mreq.size() == 0) chk("mreq_unexpected", 1, 0);
      else chk("mreq_hpl_addr", {mreqhpl_o, mreqaddr_o}, exp_mreq.pop_front());
    end
    if (!reset_i && clk_en_i && irspvalid_o && irspready_i) begin
      if (exp_irsp.size() == 0) chk("irsp_unexpected", 1, 0);
      else chk("irsp_err_data", {irsprerr_o, irspdata_o}, exp_irsp.pop_front());
    end
    if (!reset_i && clk_en_i && drspvalid_o && drspready_i) begin
      if (exp_drsp.size() == 0) chk("drsp_unexpected", 1, 0);
      else chk("drsp_err_data", {drspwerr_o, drsprerr_o, drspdata_o}, exp_drsp.pop_front());
    end
  end

  initial begin
    idle_inputs();
    reset_i = 1'b0;
    step();

    // Reset forces every valid/ready low even with all inputs asserted.
    ireqvalid_i = 1; dreqvalid_i = 1; mreqready_i = 1;
    mrspvalid_i = 1; irspready_i = 1; drspready_i = 1;
    reset_i = 1'b1;
    #1;
    chk("rst_mreqvalid", mreqvalid_o, 0);
    chk("rst_ireqready", ireqready_o, 0);
    chk("rst_dreqready", dreqready_o, 0);
    chk("rst_mrspready", mrspready_o, 0);
    chk("rst_irspvalid", irspvalid_o, 0);
    chk("rst_drspvalid", drspvalid_o, 0);
    step();
    idle_inputs();
    reset_i = 1'b0;
    step();

    // Fixed priority: D first, then I; responses return D then I.
    ireqvalid_i = 1; ireqhpl_i = 2'd1; ireqaddr_i = 32'h1000_0000;
    dreqvalid_i = 1; dreqhpl_i = 2'd3; dreqaddr_i = 32'h2000_0000;
    mreqready_i = 1;
    exp_mreq.push_back({2'd3, 32'h2000_0000});
    exp_mreq.push_back({2'd1, 32'h1000_0000});
    #1;
    chk("prio_addr_c0", mreqaddr_o, 32'h2000_0000);
    chk("prio_ireqready_c0", ireqready_o, 0);
    step();
    dreqvalid_i = 0;
    #1;
    chk("prio_addr_c1", mreqaddr_o, 32'h1000_0000);
    step();
    ireqvalid_i = 0; mreqready_i = 0;
    irspready_i = 1; drspready_i = 1; mrspvalid_i = 1; mrspwerr_i = 1; mrspdata_i = 32'hd0d0_0001;
    exp_drsp.push_back({1'b1, 1'b0, 32'hd0d0_0001});
    exp_irsp.push_back({1'b1, 32'h1111_0002});
    step();
    mrspwerr_i = 0; mrsprerr_i = 1; mrspdata_i = 32'h1111_0002;
    step();
    mrspvalid_i = 0; mrsprerr_i = 0;
    #1;
    chk("prio_drained_mrspready", mrspready_o, 0);
    do_reset();

    // Lock: a stalled I grant holds against a later D request.
    ireqvalid_i = 1; ireqhpl_i = 2'd0; ireqaddr_i = 32'h0000_0a00;
    exp_mreq.push_back({2'd0, 32'h0000_0a00});
    exp_mreq.push_back({2'd2, 32'h0000_0b00});
    step();
    dreqvalid_i = 1; dreqhpl_i = 2'd2; dreqaddr_i = 32'h0000_0b00;
    for (int c = 1; c < 3; c++) begin
      #1;
      chk("lock_addr_hold", mreqaddr_o, 32'h0000_0a00);
      chk("lock_dreqready", dreqready_o, 0);
      step();
    end
    mreqready_i = 1;
    #1;
    chk("lock_ireqready", ireqready_o, 1);
    step();
    ireqvalid_i = 0;
    #1;
    chk("lock_d_next", mreqaddr_o, 32'h0000_0b00);
    step();
    dreqvalid_i = 0; mreqready_i = 0;

    // Reset with two outstanding entries discards them.
    mrspvalid_i = 1; irspready_i = 1; drspready_i = 1;
    reset_i = 1'b1;
    #1;
    chk("rst2_mrspready", mrspready_o, 0);
    chk("rst2_irspvalid", irspvalid_o, 0);
    step();
    reset_i = 1'b0;
    step();
    chk("rst2_post_mrspready", mrspready_o, 0);
    chk("rst2_post_irspvalid", irspvalid_o, 0);
    idle_inputs();
    step();

    // Clock enable low: no request is taken, so no response is expected.
    clk_en_i = 0; ireqvalid_i = 1; mreqready_i = 1;
    step();
    clk_en_i = 1; ireqvalid_i = 0; mreqready_i = 0;
    mrspvalid_i = 1; irspready_i = 1;
    #1;
    chk("clken_no_push", mrspready_o, 0);
    step();
    idle_inputs();
    step();

    // Full: four requests fill the FIFO; the fifth waits for a pop.
    mreqready_i = 1; ireqvalid_i = 1;
    for (int k = 0; k < 4; k++) begin
      ireqaddr_i = 32'h0000_4000 + k;
      exp_mreq.push_back({2'd0, 32'h0000_4000 + k});
      step();
    end
    ireqaddr_i = 32'h0000_4004;
    exp_mreq.push_back({2'd0, 32'h0000_4004});
    #1;
    chk("full_ireqready", ireqready_o, 0);
    chk("full_mreqvalid", mreqvalid_o, 0);
    step();
    mrspvalid_i = 1; irspready_i = 1; mrspdata_i = 32'h0000_f001;
    exp_irsp.push_back({1'b0, 32'h0000_f001});
    #1;
    chk("full_pop_blocks_push", ireqready_o, 0);
    step();
    mrspvalid_i = 0;
    #1;
    chk("full_after_pop_ready", ireqready_o, 1);
    step();
    ireqvalid_i = 0; mreqready_i = 0;
    do_reset();

    // Routing I,D,I with the D sink stalled for two cycles.
    mreqready_i = 1;
    ireqvalid_i = 1; ireqaddr_i = 32'h0000_0100;
    exp_mreq.push_back({2'd0, 32'h0000_0100});
    step();
    ireqvalid_i = 0; dreqvalid_i = 1; dreqaddr_i = 32'h0000_0200;
    exp_mreq.push_back({2'd0, 32'h0000_0200});
    step();
    dreqvalid_i = 0; ireqvalid_i = 1; ireqaddr_i = 32'h0000_0300;
    exp_mreq.push_back({2'd0, 32'h0000_0300});
    step();
    ireqvalid_i = 0; mreqready_i = 0;
    exp_irsp.push_back({1'b1, 32'h0000_aaa1});
    exp_drsp.push_back({1'b1, 1'b0, 32'h0000_aaa2});
    exp_irsp.push_back({1'b0, 32'h0000_aaa3});
    mrspvalid_i = 1; irspready_i = 1; drspready_i = 0;
    mrsprerr_i = 1; mrspdata_i = 32'h0000_aaa1;
    step();
    mrsprerr_i = 0; mrspwerr_i = 1; mrspdata_i = 32'h0000_aaa2;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("route_stall_mrspready", mrspready_o, 0);
      chk("route_stall_irspvalid", irspvalid_o, 0);
      chk("route_stall_drspvalid", drspvalid_o, 1);
      step();
    end
    drspready_i = 1;
    step();
    drspready_i = 0; mrspwerr_i = 1; mrspdata_i = 32'h0000_aaa3;
    #1;
    chk("route_i_after_d", irspvalid_o, 1);
    step();
    mrspvalid_i = 0; mrspwerr_i = 0;
    #1;
    chk("route_empty_mrspready", mrspready_o, 0);
    do_reset();

`ifdef MERLIN_ARB_ROUND_ROBIN_EN
    // Round robin alternates starting from D.
    ireqvalid_i = 1; ireqaddr_i = 32'h0000_0011;
    dreqvalid_i = 1; dreqaddr_i = 32'h0000_00dd;
    mreqready_i = 1;
    for (int k = 0; k < 4; k++)
      exp_mreq.push_back({2'd0, (k % 2 == 0) ? 32'h0000_00dd : 32'h0000_0011});
    repeat (4) step();
    ireqvalid_i = 0; dreqvalid_i = 0; mreqready_i = 0;
    do_reset();
`endif

    chk("left_mreq", exp_mreq.size(), 0);
    chk("left_irsp", exp_irsp.size(), 0);
    chk("left_drsp", exp_drsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
